// File: rtl/rsr_deserializer.sv
// rsr_deserializer: serial-to-parallel capture stage behind the 4-bit rsr.
// Detects a start bit (1), shifts in WIDTH data bits LSB first and presents
// the word on a single-entry valid/ready output register with a sticky overrun
// flag. Define RSR_DESER_PARITY_EN to add a trailing even-parity bit, the PAR
// state, discard-on-failure and the sticky parity_err flag.
module rsr_deserializer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ser_in,
  input  logic             ser_valid,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             overrun,
  output logic             parity_err,
  input  logic             err_clr,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

`ifdef RSR_DESER_PARITY_EN
  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PAR} state_t;
`else
  typedef enum logic [0:0] {S_IDLE, S_DATA} state_t;
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             overrun_q, overrun_d;
  logic             commit;
  logic [WIDTH-1:0] commit_word;
  logic             overrun_set;
`ifdef RSR_DESER_PARITY_EN
  logic             parity_err_q, parity_err_d;
  logic             par_fail;
`endif

  // Receive FSM next state: start detect, data shifting, optional parity check.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    commit      = 1'b0;
    commit_word = acc_q;
`ifdef RSR_DESER_PARITY_EN
    par_fail    = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        // A 0 strobe is idle line; only a 1 starts a frame.
        if (ser_valid && ser_in) begin
          state_d = S_DATA;
          cnt_d   = '0;
          acc_d   = '0;
        end
      end
      S_DATA: begin
        if (ser_valid) begin
          // New bit enters at the MSB so the first data bit lands at bit 0.
          acc_d = {ser_in, acc_q[WIDTH-1:1]};
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
`ifdef RSR_DESER_PARITY_EN
            state_d = S_PAR;
`else
            state_d     = S_IDLE;
            commit      = 1'b1;
            commit_word = {ser_in, acc_q[WIDTH-1:1]};
`endif
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
`ifdef RSR_DESER_PARITY_EN
      S_PAR: begin
        if (ser_valid) begin
          state_d = S_IDLE;
          // Even parity: data bits plus parity bit must XOR to 0.
          if (^{acc_q, ser_in}) par_fail = 1'b1;
          else                  commit   = 1'b1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Output register and sticky flags; a pop on the commit edge frees the slot.
  always_comb begin
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    overrun_set  = 1'b0;
    if (commit) begin
      if (!dout_valid_q || dout_ready) begin
        dout_d       = commit_word;
        dout_valid_d = 1'b1;
      end else begin
        overrun_set  = 1'b1;
      end
    end else if (dout_valid_q && dout_ready) begin
      dout_valid_d = 1'b0;
    end
    // Set has priority over a simultaneous clear.
    overrun_d = overrun_set | (overrun_q & ~err_clr);
`ifdef RSR_DESER_PARITY_EN
    parity_err_d = par_fail | (parity_err_q & ~err_clr);
`endif
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      acc_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef RSR_DESER_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      overrun_q    <= overrun_d;
`ifdef RSR_DESER_PARITY_EN
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != S_IDLE);
`ifdef RSR_DESER_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_rsr_deserializer.sv
// Directed bench for rsr_deserializer (WIDTH=4): table of frames plus
// hand-written overrun, pop+commit, reset-abort and parity sequences.
module tb_rsr_deserializer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ser_in = 1'b0;
  logic       ser_valid = 1'b0;
  logic [3:0] dout;
  logic       dout_valid;
  logic       dout_ready = 1'b0;
  logic       overrun;
  logic       parity_err;
  logic       err_clr = 1'b0;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  rsr_deserializer #(.WIDTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .ser_in     (ser_in),
    .ser_valid  (ser_valid),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .overrun    (overrun),
    .parity_err (parity_err),
    .err_clr    (err_clr),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a negedge; drives one strobe through the next rising edge.
  task automatic strobe(input logic b);
    ser_valid = 1'b1;
    ser_in    = b;
    @(negedge clk);
    ser_valid = 1'b0;
    ser_in    = 1'b0;
  endtask

  // tx[i] is the i-th data bit sent; gap idle cycles precede every data bit.
  task automatic send_frame(input logic [3:0] tx, input int gap, input logic par_flip);
    strobe(1'b1);
    for (int i = 0; i < 4; i++) begin
      for (int g = 0; g < gap; g++) begin
        chk("busy_gap", 32'(busy), 32'd1);
        @(negedge clk);
      end
      strobe(tx[i]);
    end
`ifdef RSR_DESER_PARITY_EN
    strobe(^tx ^ par_flip);
`endif
  endtask

  typedef struct {
    logic [3:0] tx;
    int         gap;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{tx: 4'b0011, gap: 0, exp: 4'b0011};  // strobes 1,1,0,0
    vecs[1] = '{tx: 4'b0101, gap: 3, exp: 4'b0101};  // strobes 1,0,1,0 gapped
    vecs[2] = '{tx: 4'b1111, gap: 0, exp: 4'b1111};
    vecs[3] = '{tx: 4'b0000, gap: 1, exp: 4'b0000};  // all-zero data after start
    vecs[4] = '{tx: 4'b1000, gap: 0, exp: 4'b1000};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_valid", 32'(dout_valid), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_parity_err", 32'(parity_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Idle zeros must not start a frame
    strobe(1'b0);
    strobe(1'b0);
    chk("idle_zero_busy", 32'(busy), 32'd0);

    // Table: back-to-back frames with dout_ready held high
    dout_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      send_frame(vecs[k].tx, vecs[k].gap, 1'b0);
      chk($sformatf("tbl%0d_dout", k), 32'(dout), 32'(vecs[k].exp));
      chk($sformatf("tbl%0d_valid", k), 32'(dout_valid), 32'd1);
      chk($sformatf("tbl%0d_busy", k), 32'(busy), 32'd0);
    end
    @(negedge clk);
    chk("pop_valid", 32'(dout_valid), 32'd0);
    chk("pop_dout_hold", 32'(dout), 32'd8);

    // Overrun: output full, second word dropped
    dout_ready = 1'b0;
    send_frame(4'b0011, 0, 1'b0);
    send_frame(4'b1111, 0, 1'b0);
    chk("ovr_dout", 32'(dout), 32'h3);
    chk("ovr_valid", 32'(dout_valid), 32'd1);
    chk("ovr_flag", 32'(overrun), 32'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("ovr_clr", 32'(overrun), 32'd0);
    chk("ovr_clr_valid", 32'(dout_valid), 32'd1);
    dout_ready = 1'b1;
    @(negedge clk);
    dout_ready = 1'b0;
    chk("ovr_pop", 32'(dout_valid), 32'd0);

    // Simultaneous pop and commit on the final-bit edge
    send_frame(4'b1010, 0, 1'b0);
    chk("pc_first_valid", 32'(dout_valid), 32'd1);
    strobe(1'b1);
    strobe(1'b1);
    strobe(1'b0);
    strobe(1'b1);
`ifdef RSR_DESER_PARITY_EN
    strobe(1'b0);
`endif
    dout_ready = 1'b1;
    strobe(1'b0);
    chk("pc_dout", 32'(dout), 32'h5);
    chk("pc_valid", 32'(dout_valid), 32'd1);
    chk("pc_overrun", 32'(overrun), 32'd0);
    @(negedge clk);
    chk("pc_drain", 32'(dout_valid), 32'd0);

    // Reset mid-frame aborts the frame
    strobe(1'b1);
    strobe(1'b1);
    strobe(1'b0);
    chk("mid_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_dout", 32'(dout), 32'd0);
    chk("mid_rst_valid", 32'(dout_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_overrun", 32'(overrun), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", 32'(dout_valid), 32'd0);
    send_frame(4'b1001, 0, 1'b0);
    chk("post_rst_dout", 32'(dout), 32'h9);
    chk("post_rst_dvalid", 32'(dout_valid), 32'd1);
    @(negedge clk);

`ifdef RSR_DESER_PARITY_EN
    // Parity: good frame delivered, bad frame discarded
    send_frame(4'b0011, 0, 1'b0);
    chk("par_ok_dout", 32'(dout), 32'h3);
    chk("par_ok_err", 32'(parity_err), 32'd0);
    send_frame(4'b0111, 0, 1'b1);
    chk("par_bad_err", 32'(parity_err), 32'd1);
    chk("par_bad_valid", 32'(dout_valid), 32'd0);
    chk("par_bad_dout", 32'(dout), 32'h3);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("par_clr", 32'(parity_err), 32'd0);
`else
    chk("par_tied", 32'(parity_err), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rsr_deserializer.md
# rsr_deserializer

Serial-to-parallel receive stage that sits directly downstream of the 4-bit right shift register `rsr`. It consumes the bit stream shifted out of `rsr` (LSB first) and detects a start bit. It assembles WIDTH data bits into a parallel word and presents that word on a valid/ready output port, with overrun and (optionally) parity error reporting. It is the capture side of the serial shift path used throughout the hardware set.

## Interface
- WIDTH, default 4: data bits per frame; must be ≥2.
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset; asserting 0 clears all state immediately.
- ser_in  input  1  serial bit from the upstream shift register's LSB.
- ser_valid  input  1  bit strobe; `ser_in` is sampled only on edges where this is 1.
- dout  output  WIDTH  assembled word; bit 0 is the first data bit received.
- dout_valid  output  1  `dout` holds an unconsumed word.
- dout_ready  input  1  consumer accepts the word on an edge where `dout_valid` and `dout_ready` are both 1.
- overrun  output  1  sticky; a completed word was dropped because the output was full.
- parity_err  output  1  sticky; a frame failed the parity check (0 when parity is compiled out).
- err_clr  input  1  synchronous clear of `overrun` and `parity_err`.
- busy  output  1  the FSM is not in IDLE.

## Operation
- FSM states: IDLE, DATA, PAR (PAR exists only with parity enabled).
- IDLE → DATA: on an edge with `ser_valid`=1 and `ser_in`=1 (start bit).
  - The bit counter is cleared.
  - The shift accumulator is cleared.
  - `ser_in`=0 strobes in IDLE are ignored (line idle).
- DATA: each strobe shifts `ser_in` into the accumulator MSB side, right-shifting the rest, so the first data bit ends at bit 0.
  - The counter increments on each strobe.
  - On the strobe that delivers data bit WIDTH-1, the next state is PAR if parity is enabled, otherwise IDLE with a word commit.
  - Counter width is $clog2(WIDTH); the counter never wraps mid-frame.
- PAR: one strobe carries the parity bit; the check is even parity over the data bits plus the parity bit.
  - Pass: commit the word.
  - Fail: discard the word and set `parity_err`.
  - Either way, the next state is IDLE.
- Commit (single-entry output register):
  - If `dout_valid`=0, or `dout_ready`=1 on the same edge: load `dout` and set `dout_valid`=1.
  - Otherwise: drop the new word, keep the old `dout`, and set `overrun`.
- Pop: `dout_valid`→0 on a handshake edge with no simultaneous commit; `dout` keeps its last value.
- `err_clr`=1 clears both sticky flags.
  - If a set event occurs on the same edge, the set wins.
- Gaps in `ser_valid` are allowed anywhere; state and accumulator hold.
- The output handshake is independent of the receive FSM; the FSM never stalls on a full output.

## Timing
- Reset values: `dout`=0, `dout_valid`=0, `overrun`=0, `parity_err`=0, `busy`=0; FSM in IDLE; counter=0.
- Reset asserted mid-frame aborts the frame with no commit and no flag.
  - The first valid start bit after release begins a new frame.
- Latency: `dout_valid` is 1 in the cycle after the edge that samples the last data bit (or the parity bit).
- `busy` rises the cycle after the start-bit edge and falls the cycle after the final-bit edge.
- Minimum frame length is 1+WIDTH strobes, or 2+WIDTH with parity.
  - Back-to-back frames need no idle strobe: a start bit is accepted on the strobe right after the final bit.
- `dout` and `dout_valid` change only on clock edges, never combinationally from `dout_ready`.

## Configuration
- Macro `RSR_DESER_PARITY_EN`.
  - Defined: the PAR state, even-parity check, word discard on failure, and the `parity_err` sticky flag are all active.
  - Undefined: no PAR state; commit happens on data bit WIDTH-1; `parity_err` is tied to 0; the port list is unchanged.

## Test plan
- Basic frame, WIDTH=4, no parity, `dout_ready`=1:
  - Stimulus: strobes 1 (start), 1, 1, 0, 0.
  - Response: `dout`=4'b0011 and `dout_valid`=1 one cycle after the last strobe; `dout_valid` drops the next cycle.
- Gapped strobes:
  - Stimulus: frame 1, 0, 1, 0, 1 with 3 idle cycles between every strobe.
  - Response: `dout`=4'b1010; `busy` stays 1 throughout the gaps.
- Overrun:
  - Stimulus: `dout_ready`=0; send frames for 4'b0011 then 4'b1111.
  - Response: `dout` stays 4'b0011 and `overrun`=1. After `err_clr`, `overrun`=0.
- Simultaneous pop and commit:
  - Stimulus: hold `dout_valid`=1; assert `dout_ready` on the final-bit edge of the next frame (4'b0101).
  - Response: `dout`=4'b0101, `dout_valid` stays 1, `overrun`=0.
- Reset mid-frame:
  - Stimulus: pull `rst` low after 2 data bits, release, then send a full frame for 4'b1001.
  - Response: all outputs 0 during reset; only 4'b1001 is delivered.
- Parity (with `RSR_DESER_PARITY_EN`):
  - Stimulus: frame 4'b0011 with parity bit 0, then 4'b0111 with parity bit 0.
  - Response: first word delivered; second word discarded and `parity_err`=1.
